// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage core.
// Resolves the hazards that operand forwarding cannot:
//   - load-use stall,
//   - taken-branch squash,
//   - freeze behind a multi-cycle MDU op held in EX.
// Also keeps saturating stall/flush counters for performance debug.
module hazard_ctrl #(
  parameter int MDU_LAT = 4,   // cycles an MDU op occupies EX (2..255)
  parameter int CNT_W   = 32   // width of the statistics counters
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [4:0]       id_reg_rs,
  input  logic [4:0]       id_reg_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_reg_rd,
  input  logic             ex_branch_taken,
  input  logic             ex_mdu_start,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mdu_done,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {S_RUN, S_MDU_WAIT} state_t;

  // The counter is loaded with MDU_LAT-1 so that the start cycle plus
  // MDU_LAT-2 wait cycles are frozen and the final wait cycle releases.
  // With MDU_LAT=2 this loads 1, giving one MDU_WAIT cycle that is
  // directly the done cycle.
  localparam logic [7:0] LAT_M1 = 8'(MDU_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  logic [7:0]       r_mdu_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_load_use;
  logic w_rs_hit;
  logic w_rt_hit;

  // Load-use detection: a load to r0 never creates a dependency.
  always_comb begin
    w_rs_hit   = (ex_reg_rd == id_reg_rs);
    w_rt_hit   = id_uses_rt && (ex_reg_rd == id_reg_rt);
    w_load_use = ex_mem_read && (ex_reg_rd != 5'd0) && (w_rs_hit || w_rt_hit);
  end

  // Control outputs, combinational from state, counter and inputs; forced
  // to the free-running pattern while reset is asserted.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mdu_done     = 1'b0;
    if (arst_n) begin
      if (r_state == S_RUN) begin
        if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (ex_mdu_start) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_mem_flush = 1'b1;
        end else if (w_load_use) begin
          // Hold PC and IF/ID, inject one bubble into ID/EX.
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
      end else begin
        if (r_mdu_cnt > 8'd1) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_mem_flush = 1'b1;
        end else begin
          mdu_done = 1'b1;
        end
      end
    end
  end

  // Sequencing FSM and MDU latency counter.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state   <= S_RUN;
      r_mdu_cnt <= 8'd0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (!ex_branch_taken && ex_mdu_start) begin
            r_state   <= S_MDU_WAIT;
            r_mdu_cnt <= LAT_M1;
          end
        end
        default: begin
          if (r_mdu_cnt > 8'd1) begin
            r_mdu_cnt <= r_mdu_cnt - 8'd1;
          end else begin
            r_state   <= S_RUN;
            r_mdu_cnt <= 8'd0;
          end
        end
      endcase
    end
  end

  // Saturating statistics: stalled cycles and taken-branch flushes.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!pc_en && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (if_id_flush && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  // A stall and a branch squash are mutually exclusive in any cycle.
  a_stall_xor_flush : assert property (@(posedge clk) disable iff (!arst_n)
    !(!pc_en && if_id_flush));

  // mdu_done can only come out of the wait state.
  a_done_in_wait : assert property (@(posedge clk) disable iff (!arst_n)
    mdu_done |-> (r_state == S_MDU_WAIT));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with a queue-based scoreboard.
module tb_hazard_ctrl;

  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 4;

  // Expected control pattern: {pc_en,if_id_en,id_ex_en,if_id_flush,id_ex_flush,ex_mem_flush,mdu_done}
  localparam logic [6:0] C_IDLE = 7'b1110000;
  localparam logic [6:0] C_LU   = 7'b0010100;
  localparam logic [6:0] C_BR   = 7'b1111100;
  localparam logic [6:0] C_FRZ  = 7'b0000010;
  localparam logic [6:0] C_DONE = 7'b1110001;

  logic             clk;
  logic             arst_n;
  logic [4:0]       id_reg_rs;
  logic [4:0]       id_reg_rt;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [4:0]       ex_reg_rd;
  logic             ex_branch_taken;
  logic             ex_mdu_start;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             mdu_done;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  hazard_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .id_reg_rs      (id_reg_rs),
    .id_reg_rt      (id_reg_rt),
    .id_uses_rt     (id_uses_rt),
    .ex_mem_read    (ex_mem_read),
    .ex_reg_rd      (ex_reg_rd),
    .ex_branch_taken(ex_branch_taken),
    .ex_mdu_start   (ex_mdu_start),
    .pc_en          (pc_en),
    .if_id_en       (if_id_en),
    .id_ex_en       (id_ex_en),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .ex_mem_flush   (ex_mem_flush),
    .mdu_done       (mdu_done),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       mem_read;
    logic [4:0] rd;
    logic       br;
    logic       mdu;
    logic [6:0] ctrl;
    int         stall;
    int         flush;
  } vec_t;

  typedef struct {
    int         idx;
    logic [6:0] ctrl;
    int         stall;
    int         flush;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic add(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                     input logic uses_rt, input logic mem_read, input logic [4:0] rd,
                     input logic br, input logic mdu, input logic [6:0] ctrl,
                     input int stall, input int flush);
    vec_t v;
    v.rst = rst; v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.mem_read = mem_read;
    v.rd = rd; v.br = br; v.mdu = mdu; v.ctrl = ctrl; v.stall = stall; v.flush = flush;
    vecs.push_back(v);
  endtask

  // Monitor: each cycle the bench presents a vector, compare at the falling edge.
  initial begin
    exp_t       e;
    logic [6:0] got;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        got = {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_flush, mdu_done};
        n_checks += 3;
        if (got !== e.ctrl) begin
          n_err++;
          $display("FAIL v%0d ctrl: got %b want %b", e.idx, got, e.ctrl);
        end
        if (int'(stall_cnt) != e.stall) begin
          n_err++;
          $display("FAIL v%0d stall_cnt: got %0d want %0d", e.idx, stall_cnt, e.stall);
        end
        if (int'(flush_cnt) != e.flush) begin
          n_err++;
          $display("FAIL v%0d flush_cnt: got %0d want %0d", e.idx, flush_cnt, e.flush);
        end
        $display("v%0d ctrl=%b stall=%0d flush=%0d", e.idx, got, stall_cnt, flush_cnt);
      end
    end
  end

  initial begin
    exp_t e;
    int   wait_cyc;

    arst_n = 1'b0; id_reg_rs = '0; id_reg_rt = '0; id_uses_rt = 1'b0;
    ex_mem_read = 1'b0; ex_reg_rd = '0; ex_branch_taken = 1'b0; ex_mdu_start = 1'b0;

    //   rst rs  rt  urt mrd rd  br mdu ctrl    stall flush
    // Load-use and r0 / unused-rt cases
    add(1, 0,  0,  0,  0,  0,  0, 0,  C_IDLE, 0,  0);   // v0  reset
    add(0, 0,  0,  0,  0,  0,  0, 0,  C_IDLE, 0,  0);   // v1
    add(0, 5,  0,  0,  1,  5,  0, 0,  C_LU,   0,  0);   // v2  ld r5, ID rs=5
    add(0, 5,  0,  0,  0,  0,  0, 0,  C_IDLE, 1,  0);   // v3  bubble in EX
    add(0, 0,  0,  0,  1,  0,  0, 0,  C_IDLE, 1,  0);   // v4  ld r0
    add(0, 3,  5,  0,  1,  5,  0, 0,  C_IDLE, 1,  0);   // v5  rt=5 but unused
    add(0, 3,  5,  1,  1,  5,  0, 0,  C_LU,   1,  0);   // v6  rt=5 used
    add(0, 0,  0,  0,  0,  0,  0, 0,  C_IDLE, 2,  0);   // v7
    // Branch beats load-use
    add(1, 0,  0,  0,  0,  0,  0, 0,  C_IDLE, 0,  0);   // v8  reset
    add(0, 5,  0,  0,  1,  5,  1, 0,  C_BR,   0,  0);   // v9
    add(0, 5,  0,  0,  1,  5,  1, 0,  C_BR,   0,  1);   // v10
    add(0, 5,  0,  0,  1,  5,  1, 0,  C_BR,   0,  2);   // v11
    add(0, 0,  0,  0,  0,  0,  0, 0,  C_IDLE, 0,  3);   // v12
    // Back-to-back MDU ops
    add(1, 0,  0,  0,  0,  0,  0, 0,  C_IDLE, 0,  0);   // v13 reset
    add(0, 0,  0,  0,  0,  0,  0, 1,  C_FRZ,  0,  0);   // v14 MDU start
    add(0, 5,  0,  0,  1,  5,  1, 1,  C_FRZ,  1,  0);   // v15 inputs ignored
    add(0, 0,  0,  0,  0,  0,  0, 0,  C_FRZ,  2,  0);   // v16
    add(0, 0,  0,  0,  0,  0,  0, 0,  C_DONE, 3,  0);   // v17 done, cycle 4
    add(0, 0,  0,  0,  0,  0,  0, 1,  C_FRZ,  3,  0);   // v18 second op
    add(0, 0,  0,  0,  0,  0,  0, 0,  C_FRZ,  4,  0);   // v19
    add(0, 0,  0,  0,  0,  0,  0, 0,  C_FRZ,  5,  0);   // v20
    add(0, 0,  0,  0,  0,  0,  0, 0,  C_DONE, 6,  0);   // v21 done, cycle 8
    add(0, 0,  0,  0,  0,  0,  0, 0,  C_IDLE, 6,  0);   // v22
    // Reset during MDU wait
    add(0, 0,  0,  0,  0,  0,  0, 1,  C_FRZ,  6,  0);   // v23 MDU start
    add(0, 0,  0,  0,  0,  0,  0, 0,  C_FRZ,  7,  0);   // v24 wait
    add(1, 0,  0,  0,  0,  0,  0, 0,  C_IDLE, 0,  0);   // v25 reset mid-MDU
    add(0, 0,  0,  0,  0,  0,  0, 0,  C_IDLE, 0,  0);   // v26
    add(0, 0,  0,  0,  0,  0,  0, 0,  C_IDLE, 0,  0);   // v27
    add(0, 0,  0,  0,  0,  0,  0, 0,  C_IDLE, 0,  0);   // v28
    // 20 continuous load-use stalls saturate the 4-bit counter at 15
    for (int k = 0; k < 20; k++) begin
      add(0, 5, 0, 0, 1, 5, 0, 0, C_LU, (k < 15) ? k : 15, 0);
    end
    add(0, 0,  0,  0,  0,  0,  0, 0,  C_IDLE, 15, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      arst_n          = ~vecs[i].rst;
      id_reg_rs       = vecs[i].rs;
      id_reg_rt       = vecs[i].rt;
      id_uses_rt      = vecs[i].uses_rt;
      ex_mem_read     = vecs[i].mem_read;
      ex_reg_rd       = vecs[i].rd;
      ex_branch_taken = vecs[i].br;
      ex_mdu_start    = vecs[i].mdu;
      e.idx   = i;
      e.ctrl  = vecs[i].ctrl;
      e.stall = vecs[i].stall;
      e.flush = vecs[i].flush;
      sb.push_back(e);
    end

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    #2;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core.
- Produces the stage enables and flushes that the operand-forwarding logic cannot resolve:
  - load-use stall,
  - taken-branch squash,
  - freeze for a multi-cycle multiply/divide (MDU) instruction held in EX.
- Sits beside the forwarding unit and drives the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Keeps saturating stall and flush counters for performance debug.

Parameters:
- MDU_LAT, 4, cycles an MDU instruction occupies EX (legal range 2..255).
- CNT_W, 32, width of the stall_cnt and flush_cnt counters.

Ports:
- clk  in  1  core clock
- arst_n  in  1  asynchronous active-low reset
- id_reg_rs  in  5  rs of the instruction in ID
- id_reg_rt  in  5  rt of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- ex_mem_read  in  1  EX instruction is a load
- ex_reg_rd  in  5  destination register of the EX instruction
- ex_branch_taken  in  1  branch/jump in EX resolved taken
- ex_mdu_start  in  1  EX instruction is a multi-cycle MDU op
- pc_en  out  1  PC update enable
- if_id_en  out  1  IF/ID register enable
- id_ex_en  out  1  ID/EX register enable
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_flush  out  1  load NOP into ID/EX
- ex_mem_flush  out  1  load NOP into EX/MEM
- mdu_done  out  1  MDU result valid in EX this cycle
- stall_cnt  out  CNT_W  cycles with pc_en=0
- flush_cnt  out  CNT_W  taken-branch flushes

Behaviour:
- Clocking and reset:
  - One clock domain, clk. Reset is asynchronous and active-low on arst_n.
  - While arst_n=0:
    - state=RUN, mdu counter=0, stall_cnt=0, flush_cnt=0.
    - Outputs are forced: pc_en=if_id_en=id_ex_en=1, all flushes=0, mdu_done=0.
- Output timing:
  - Control outputs are combinational from state, counter and inputs.
  - All state, counter and statistics updates occur on the rising edge of clk.
- FSM, 2 states:
  - RUN: normal issue.
  - MDU_WAIT: pipeline frozen behind an MDU op in EX.
- Priority in RUN, highest first:
  1. ex_branch_taken:
     - if_id_flush=1, id_ex_flush=1, all enables=1.
     - flush_cnt+1.
     - ex_mdu_start and load-use are ignored this cycle.
  2. ex_mdu_start:
     - pc_en=if_id_en=id_ex_en=0, ex_mem_flush=1.
     - Counter loads MDU_LAT-1; next state MDU_WAIT.
     - Exception: if MDU_LAT=2 the next state is still MDU_WAIT, with counter=1.
  3. Load-use hazard:
     - Condition: ex_mem_read=1, ex_reg_rd!=0, and either ex_reg_rd==id_reg_rs or (id_uses_rt=1 and ex_reg_rd==id_reg_rt).
     - Response: pc_en=0, if_id_en=0, id_ex_flush=1, id_ex_en=1.
     - Exactly one bubble; state stays RUN. The hazard clears by itself next cycle because EX now holds the NOP.
  4. Otherwise: all enables=1, all flushes=0.
- MDU_WAIT:
  - While counter>1:
    - pc_en=if_id_en=id_ex_en=0, ex_mem_flush=1.
    - Counter decrements.
  - When counter==1:
    - mdu_done=1, all enables=1, ex_mem_flush=0; the MDU op advances to MEM.
    - Next state RUN, counter<=0.
  - ex_branch_taken, ex_mdu_start and load-use inputs are ignored in MDU_WAIT.
  - Net effect: the MDU op occupies EX for exactly MDU_LAT cycles, with MDU_LAT-1 frozen cycles.
- Back-to-back MDU ops:
  - The second op enters EX in the cycle after mdu_done and is seen in RUN as a fresh ex_mdu_start.
  - No lost cycles.
- Register $zero: a load to r0 never stalls.
- stall_cnt:
  - +1 on every clk edge where arst_n=1 and pc_en=0.
  - Saturates at 2^CNT_W-1; no wrap.
- flush_cnt: +1 per taken-branch cycle; saturates the same way.
- Reset mid-MDU: asynchronous return to RUN with counters cleared. mdu_done never pulses for the aborted op.
- Invariants for assertions:
  - At most one of {pc_en=0, if_id_flush=1} per cycle.
  - mdu_done implies state==MDU_WAIT.

Test Plan:
- Reset, then ld r5 in EX with ID reading rs=5 -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1. Next cycle all enables=1. stall_cnt=1.
- ld r0 in EX with ID rs=0; and ld r5 with id_uses_rt=0, rt=5 -> no stall in either case; stall_cnt unchanged.
- ex_branch_taken=1 together with the load-use condition, repeated 3 times -> flushes win each time with pc_en=1. flush_cnt=3, stall_cnt=0.
- MDU_LAT=4, ex_mdu_start pulse -> 3 frozen cycles with ex_mem_flush=1, then mdu_done=1 on the 4th cycle with enables=1. Two back-to-back MDU ops give mdu_done at cycles 4 and 8; stall_cnt=6.
- arst_n low during the 2nd MDU_WAIT cycle -> outputs immediately pc_en=1, mdu_done=0, counters 0. After release, state is RUN and no mdu_done occurs.
- CNT_W=4 with 20 continuous load-use stalls -> stall_cnt saturates at 15 and holds.
